alu_serial: RTL and testbench

Parametrised multi-cycle ALU, the sequential successor of the 1-bit ALU slice. It supports the same four operations (NOR, XOR, ADD, SUB) on WIDTH-bit operands, processing SLICE bits per clock LSB-first, and keeps the carry in a register between chunks. Operands are latched on a start/busy/done handshake, and the unit reports carry, signed-overflow and zero flags alongside the result. It is intended as the arithmetic unit for the course's small datapath and controller blocks.

---
 rtl/alu_serial.sv | 149 ++++++++++++++
 tb/tb_alu_serial.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// Multi-cycle NOR/XOR/ADD/SUB unit that walks WIDTH-bit operands SLICE bits per clock, LSB first,
// carrying between chunks and reporting carry, signed-overflow and zero flags on a done pulse.
module alu_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("alu_serial: WIDTH must be >= 2 and a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {OP_NOR = 2'b00, OP_XOR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_e;
  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, nz_q, nz_d;
  logic             done_q, done_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [SLICE-1:0] a_c, b_c, b_eff, chunk;
  logic [SLICE:0]   sum;
  logic             arith, last, msb_cin;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    nz_d     = nz_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    // Operands are shifted right each chunk, so the current chunk is always the low SLICE bits.
    a_c     = a_q[SLICE-1:0];
    b_c     = b_q[SLICE-1:0];
    arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    b_eff   = (op_q == OP_SUB) ? ~b_c : b_c;
    sum     = {1'b0, a_c} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
    msb_cin = a_c[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
    last    = (idx_q == CW'(N - 1));

    unique case (op_q)
      OP_NOR:  chunk = ~(a_c | b_c);
      OP_XOR:  chunk = a_c ^ b_c;
      default: chunk = sum[SLICE-1:0];
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op_e'(op);
          idx_d   = '0;
          carry_d = (op == OP_SUB);
          nz_d    = 1'b0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        acc_d   = (acc_q >> SLICE) | (WIDTH'(chunk) << (WIDTH - SLICE));
        carry_d = arith & sum[SLICE];
        nz_d    = nz_q | (|chunk);
        idx_d   = idx_q + CW'(1);
        if (last) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = acc_d;
          cout_d   = carry_d;
          ovf_d    = arith & (msb_cin ^ sum[SLICE]);
          zero_d   = ~nz_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOR;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      nz_q     <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      nz_q     <= nz_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Randomised self-checking bench for alu_serial: an 8-bit/1-bit instance and a 16-bit/4-bit
// instance are compared against a whole-word arithmetic reference model.
module tb_alu_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s8_start, s8_busy, s8_done, s8_cout, s8_ovf, s8_zero;
  logic [1:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_result;
  logic        s16_start, s16_busy, s16_done, s16_cout, s16_ovf, s16_zero;
  logic [1:0]  s16_op;
  logic [15:0] s16_a, s16_b, s16_result;

  alu_serial #(.WIDTH(8), .SLICE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .op(s8_op), .a(s8_a), .b(s8_b),
    .busy(s8_busy), .done(s8_done), .result(s8_result),
    .cout(s8_cout), .ovf(s8_ovf), .zero(s8_zero)
  );

  alu_serial #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16_start), .op(s16_op), .a(s16_a), .b(s16_b),
    .busy(s16_busy), .done(s16_done), .result(s16_result),
    .cout(s16_cout), .ovf(s16_ovf), .zero(s16_zero)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } obs_t;

  localparam logic [1:0] NOR_OP = 2'b00, XOR_OP = 2'b01, ADD_OP = 2'b10, SUB_OP = 2'b11;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt[2] = '{0, 0};
  logic [15:0] prev_res[2] = '{16'h0, 16'h0};

  always @(posedge clk) begin
    #1;
    if (s8_done)  done_cnt[0]++;
    if (s16_done) done_cnt[1]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : 16;
  endfunction

  function automatic int n_of(input int sel);
    return (sel == 0) ? 8 : 4;
  endfunction

  // Whole-word reference: plain arithmetic plus the signed-overflow sign rules.
  function automatic obs_t model(input logic [1:0] op, input logic [15:0] a_in,
                                 input logic [15:0] b_in, input int w);
    logic [31:0] mask, a, b, full;
    logic        sa, sb, sr;
    obs_t        e;
    mask = (32'd1 << w) - 32'd1;
    a    = {16'd0, a_in} & mask;
    b    = {16'd0, b_in} & mask;
    case (op)
      NOR_OP:  full = ~(a | b) & mask;
      XOR_OP:  full = a ^ b;
      ADD_OP:  full = a + b;
      default: full = a + (~b & mask) + 32'd1;
    endcase
    e.res  = 16'(full & mask);
    e.cout = op[1] ? full[w] : 1'b0;
    sa = a[w-1];
    sb = b[w-1];
    sr = full[w-1];
    e.ovf = 1'b0;
    if (op == ADD_OP)      e.ovf = (sa == sb) && (sr != sa);
    else if (op == SUB_OP) e.ovf = (sa != sb) && (sr != sa);
    e.zero = (e.res == 16'd0);
    return e;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (sel == 0) begin
      s8_start = st; s8_op = op; s8_a = a[7:0]; s8_b = b[7:0];
    end else begin
      s16_start = st; s16_op = op; s16_a = a; s16_b = b;
    end
  endtask

  function automatic obs_t observe(input int sel);
    obs_t o;
    if (sel == 0) o = '{res: {8'd0, s8_result}, cout: s8_cout, ovf: s8_ovf, zero: s8_zero};
    else          o = '{res: s16_result, cout: s16_cout, ovf: s16_ovf, zero: s16_zero};
    return o;
  endfunction

  function automatic logic dut_busy(input int sel);
    return (sel == 0) ? s8_busy : s16_busy;
  endfunction

  function automatic logic dut_done(input int sel);
    return (sel == 0) ? s8_done : s16_done;
  endfunction

  // Called just after a falling edge; returns at the falling edge inside the done cycle.
  task automatic run_op(input int sel, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input bit disturb, input string name);
    obs_t e, o;
    int   cycles, dc0;
    e   = model(op, a, b, width_of(sel));
    dc0 = done_cnt[sel];
    drive(sel, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    o = observe(sel);
    check({name, " busy after start"}, 32'(dut_busy(sel)), 32'd1);
    check({name, " result held in run"}, 32'(o.res), 32'(prev_res[sel]));
    cycles = 0;
    @(negedge clk);
    drive(sel, disturb, 2'($urandom), 16'($urandom), 16'($urandom));
    while (!dut_done(sel) && cycles < 64) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      drive(sel, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
    end
    o = observe(sel);
    check({name, " latency"}, 32'(cycles), 32'(n_of(sel)));
    check({name, " result"}, 32'(o.res), 32'(e.res));
    check({name, " cout"}, 32'(o.cout), 32'(e.cout));
    check({name, " ovf"}, 32'(o.ovf), 32'(e.ovf));
    check({name, " zero"}, 32'(o.zero), 32'(e.zero));
    check({name, " done count"}, 32'(done_cnt[sel]), 32'(dc0 + 1));
    prev_res[sel] = e.res;
  endtask

  task automatic check_cleared(input int sel, input string name);
    obs_t o;
    o = observe(sel);
    check({name, " busy"}, 32'(dut_busy(sel)), 32'd0);
    check({name, " done"}, 32'(dut_done(sel)), 32'd0);
    check({name, " result"}, 32'(o.res), 32'd0);
    check({name, " cout"}, 32'(o.cout), 32'd0);
    check({name, " ovf"}, 32'(o.ovf), 32'd0);
    check({name, " zero"}, 32'(o.zero), 32'd0);
  endtask

  initial begin
    int dc;
    drive(0, 1'b0, 2'b00, 16'h0, 16'h0);
    drive(1, 1'b0, 2'b00, 16'h0, 16'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared(0, "reset w8");
    check_cleared(1, "reset w16");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, ADD_OP, 16'h7F, 16'h01, 1'b0, "add 7f+01");
    run_op(0, ADD_OP, 16'hFF, 16'h01, 1'b0, "add ff+01");
    run_op(0, SUB_OP, 16'h05, 16'h05, 1'b0, "sub 05-05");
    run_op(0, SUB_OP, 16'h80, 16'h01, 1'b0, "sub 80-01");
    run_op(0, NOR_OP, 16'hF0, 16'h0C, 1'b0, "nor f0,0c");
    run_op(0, XOR_OP, 16'hAA, 16'hAA, 1'b0, "xor aa,aa");

    // Start pulse and operand changes during RUN must be ignored and not queued.
    run_op(0, ADD_OP, 16'h3C, 16'h45, 1'b1, "disturbed add");
    dc = done_cnt[0];
    drive(0, 1'b0, 2'b00, 16'h0, 16'h0);
    repeat (4) @(negedge clk);
    check("no queued op busy", 32'(dut_busy(0)), 32'd0);
    check("single done pulse", 32'(done_cnt[0]), 32'(dc));

    // The second call starts in the done cycle of the first.
    run_op(0, SUB_OP, 16'h10, 16'h20, 1'b0, "b2b first");
    run_op(0, XOR_OP, 16'h5A, 16'h0F, 1'b0, "b2b second");
    drive(0, 1'b0, 2'b00, 16'h0, 16'h0);

    run_op(1, ADD_OP, 16'h8000, 16'h8000, 1'b0, "w16 add 8000+8000");
    drive(1, 1'b0, 2'b00, 16'h0, 16'h0);
    @(negedge clk);

    // Asynchronous reset in the middle of an ADD clears everything at once.
    dc = done_cnt[0];
    drive(0, 1'b1, ADD_OP, 16'h12, 16'h34);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 2'b00, 16'h0, 16'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared(0, "mid-run reset immediate");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_cleared(0, "mid-run reset after 10");
    check("mid-run reset no done", 32'(done_cnt[0]), 32'(dc));
    prev_res[0] = 16'h0;
    prev_res[1] = 16'h0;

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      run_op(sel, 2'($urandom), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 3) == 0), $sformatf("rand %0d", i));
      if ($urandom_range(0, 2) == 0) begin
        drive(sel, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drive(0, 1'b0, 2'b00, 16'h0, 16'h0);
    drive(1, 1'b0, 2'b00, 16'h0, 16'h0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
